// File: rtl/psum_binarize_pack_if.sv
// Bus bundle for psum_binarize_pack: threshold load, psum stream, flush and
// packed activation output. Optional macro BN_FLIP_EN widens thr_data by one
// flip bit.
interface psum_binarize_pack_if #(
  parameter int WIDTH = 14,
  parameter int PACK  = 27
);
`ifdef BN_FLIP_EN
  localparam int TW = WIDTH + 1;
`else
  localparam int TW = WIDTH;
`endif

  logic             thr_load;
  logic [TW-1:0]    thr_data;
  logic             psum_valid;
  logic [WIDTH-1:0] psum_in;
  logic             psum_ready;
  logic             flush;
  logic             act_valid;
  logic [PACK-1:0]  act_out;
  logic             act_ready;

  // Upstream producer / downstream consumer view
  modport master (
    output thr_load, thr_data, psum_valid, psum_in, flush, act_ready,
    input  psum_ready, act_valid, act_out
  );

  // Block view
  modport slave (
    input  thr_load, thr_data, psum_valid, psum_in, flush, act_ready,
    output psum_ready, act_valid, act_out
  );
endinterface

// File: rtl/psum_binarize_pack.sv
// psum_binarize_pack: binarizes a serial stream of signed partial sums
// against per-channel thresholds and packs the bits LSB-first into PACK-bit
// words, delivered through a 2-entry valid/ready output buffer.
// Optional macro BN_FLIP_EN: per-channel flip bit (thr_data MSB) inverts the
// binarized output of that channel.
module psum_binarize_pack #(
  parameter int WIDTH = 14,
  parameter int O_CH  = 9,
  parameter int PACK  = 27
) (
  input logic                  clk_in,
  input logic                  rst_in,
  psum_binarize_pack_if.slave  bus
);
  localparam int CW = (O_CH > 1) ? $clog2(O_CH) : 1;
  localparam int BW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(O_CH - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(PACK - 1);

  logic signed [WIDTH-1:0] thr_q [O_CH];
`ifdef BN_FLIP_EN
  logic [O_CH-1:0] flip_q;
`endif
  logic [CW-1:0]   load_ptr_q;
  logic [CW-1:0]   ch_q, ch_d;
  logic [BW-1:0]   bit_ptr_q, bit_ptr_d;
  logic [PACK-1:0] shift_q, shift_d;
  logic            flush_pending_q, flush_pending_d;

  logic [PACK-1:0] fifo_q [2];
  logic            wr_ptr_q, rd_ptr_q;
  logic [1:0]      count_q;

  logic            fifo_full, psum_ready_w, accept, pop, push, bin_bit, flush_act;
  logic [PACK-1:0] word_acc;

  // Handshake qualifiers and the binarized bit of the current psum
  always_comb begin
    fifo_full    = (count_q == 2'd2);
    psum_ready_w = !rst_in && !bus.thr_load && !fifo_full;
    accept       = bus.psum_valid && psum_ready_w;
    pop          = (count_q != 2'd0) && bus.act_ready;
    bin_bit      = ($signed(bus.psum_in) >= thr_q[ch_q]);
`ifdef BN_FLIP_EN
    bin_bit      = bin_bit ^ flip_q[ch_q];
`endif
    word_acc     = accept ? (shift_q | (PACK'(bin_bit) << bit_ptr_q)) : shift_q;
  end

  assign bus.psum_ready = psum_ready_w;
  assign bus.act_valid  = (count_q != 2'd0);
  assign bus.act_out    = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;

  // Packing next-state: the accepted bit is merged before a flush is judged,
  // and a word-completing accept absorbs any flush request (no second push)
  always_comb begin
    flush_act       = bus.flush || flush_pending_q;
    ch_d            = ch_q;
    bit_ptr_d       = bit_ptr_q;
    shift_d         = word_acc;
    flush_pending_d = flush_act;
    push            = 1'b0;
    if (accept) begin
      ch_d      = (ch_q == CH_LAST) ? '0 : ch_q + CW'(1);
      bit_ptr_d = (bit_ptr_q == BIT_LAST) ? '0 : bit_ptr_q + BW'(1);
    end
    if (accept && (bit_ptr_q == BIT_LAST)) begin
      push            = 1'b1;
      shift_d         = '0;
      flush_pending_d = 1'b0;
    end else if (flush_act && !fifo_full) begin
      push            = accept || (bit_ptr_q != '0);
      ch_d            = '0;
      bit_ptr_d       = '0;
      shift_d         = '0;
      flush_pending_d = 1'b0;
    end
  end

  // Threshold table written round-robin by thr_load
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < O_CH; i++) thr_q[i] <= '0;
`ifdef BN_FLIP_EN
      flip_q     <= '0;
`endif
      load_ptr_q <= '0;
    end else if (bus.thr_load) begin
      thr_q[load_ptr_q] <= $signed(bus.thr_data[WIDTH-1:0]);
`ifdef BN_FLIP_EN
      flip_q[load_ptr_q] <= bus.thr_data[WIDTH];
`endif
      load_ptr_q <= (load_ptr_q == CH_LAST) ? '0 : load_ptr_q + CW'(1);
    end
  end

  // Packing state registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ch_q            <= '0;
      bit_ptr_q       <= '0;
      shift_q         <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      ch_q            <= ch_d;
      bit_ptr_q       <= bit_ptr_d;
      shift_q         <= shift_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  // 2-entry output FIFO; pushes only occur when not full
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= word_acc;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_psum_binarize_pack.sv
// Self-checking bench for psum_binarize_pack: table-driven word vectors,
// hand sequences for backpressure/flush/reset, and a randomized phase, all
// checked against a bit-queue reference model sampled on the falling edge.
module tb_psum_binarize_pack;
  localparam int WIDTH = 14;
  localparam int O_CH  = 9;
  localparam int PACK  = 27;
`ifdef BN_FLIP_EN
  localparam int TW = WIDTH + 1;
`else
  localparam int TW = WIDTH;
`endif

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int compared = 0;
  int mismatched = 0;
  int pops = 0;
  int cyc = 0;
  logic [PACK-1:0] last_word = '0;

  psum_binarize_pack_if #(.WIDTH(WIDTH), .PACK(PACK)) bus ();

  psum_binarize_pack #(.WIDTH(WIDTH), .O_CH(O_CH), .PACK(PACK)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Reference model state
  int              m_thr [O_CH];
  bit              m_flip[O_CH];
  int              m_lp, m_ch;
  bit              m_bits[$];
  logic [PACK-1:0] m_q[$];
  bit              m_pend;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [PACK-1:0] pack_bits(input bit b[$]);
    logic [PACK-1:0] w = '0;
    foreach (b[i]) if (b[i]) w = w + (PACK'(1) << i);
    return w;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < O_CH; i++) begin m_thr[i] = 0; m_flip[i] = 0; end
    m_lp = 0; m_ch = 0; m_pend = 0;
    m_bits.delete(); m_q.delete();
  endtask

  // Falling-edge monitor: check outputs, then advance the model by what the
  // coming rising edge will do
  always @(negedge clk_in) begin
    int unsigned cnt;
    int p;
    bit b, done, freq;
    if (rst_in) begin
      chk("rst_act_valid", bus.act_valid, 0);
      chk("rst_act_out", bus.act_out, 0);
      chk("rst_psum_ready", bus.psum_ready, 0);
      m_reset();
    end else begin
      cnt = m_q.size();
      chk("psum_ready", bus.psum_ready, (cnt < 2) && !bus.thr_load);
      chk("act_valid", bus.act_valid, cnt != 0);
      chk("act_out", bus.act_out, (cnt != 0) ? m_q[0] : '0);
      if (cnt != 0 && bus.act_ready) begin
        last_word = bus.act_out;
        pops++;
        void'(m_q.pop_front());
      end
      if (bus.thr_load) begin
        m_thr[m_lp] = $signed(bus.thr_data[WIDTH-1:0]);
`ifdef BN_FLIP_EN
        m_flip[m_lp] = bus.thr_data[WIDTH];
`endif
        m_lp = (m_lp + 1) % O_CH;
      end
      done = 0;
      if (bus.psum_valid && cnt < 2 && !bus.thr_load) begin
        p = $signed(bus.psum_in);
        b = (p >= m_thr[m_ch]) ^ m_flip[m_ch];
        m_bits.push_back(b);
        m_ch = (m_ch + 1) % O_CH;
        if (m_bits.size() == PACK) begin
          m_q.push_back(pack_bits(m_bits));
          m_bits.delete();
          done = 1;
        end
      end
      freq = m_pend || bus.flush;
      if (done) m_pend = 0;
      else if (freq && cnt < 2) begin
        if (m_bits.size() != 0) m_q.push_back(pack_bits(m_bits));
        m_bits.delete();
        m_ch = 0;
        m_pend = 0;
      end else m_pend = freq;
    end
  end

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic load_thr(input int thr, input bit fl);
    bus.thr_load = 1'b1;
`ifdef BN_FLIP_EN
    bus.thr_data = {fl, WIDTH'(thr)};
`else
    bus.thr_data = WIDTH'(thr);
    if (fl) bus.thr_data = WIDTH'(thr);
`endif
    tick();
    bus.thr_load = 1'b0;
  endtask

  task automatic send_psum(input int v);
    int n = 0;
    bus.psum_valid = 1'b1;
    bus.psum_in = WIDTH'(v);
    @(negedge clk_in);
    while (!bus.psum_ready && n < 300) begin n++; @(negedge clk_in); end
    if (n >= 300) chk("send_timeout", 1, 0);
    tick();
    bus.psum_valid = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pops < target && n < 300) begin tick(); n++; end
    chk(name, pops, target);
  endtask

  typedef struct {
    int              thr;
    int              pe;
    int              po;
    logic [PACK-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int p0, c0, acc, bpn;
    bit stalled;

    tbl[0] = '{thr: 0,     pe: 5,     po: -3,    exp: 27'h5555555};
    tbl[1] = '{thr: 100,   pe: 100,   po: 100,   exp: 27'h7FFFFFF};
    tbl[2] = '{thr: 100,   pe: 99,    po: 99,    exp: 27'h0000000};
    tbl[3] = '{thr: -8192, pe: -8192, po: -8192, exp: 27'h7FFFFFF};
    tbl[4] = '{thr: 8191,  pe: -8192, po: 8191,  exp: 27'h2AAAAAA};
    tbl[5] = '{thr: 0,     pe: -1,    po: 0,     exp: 27'h2AAAAAA};

    bus.thr_load = 0; bus.thr_data = '0; bus.psum_valid = 0; bus.psum_in = '0;
    bus.flush = 0; bus.act_ready = 1;
    m_reset();

    // Reset and idle
    repeat (3) tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("ready_after_reset", bus.psum_ready, 1);
    repeat (20) tick();
    chk("idle_no_words", pops, 0);
    chk("idle_act_valid", bus.act_valid, 0);

    // Table-driven full words with uniform thresholds
    foreach (tbl[r]) begin
      for (int k = 0; k < O_CH; k++) load_thr(tbl[r].thr, 0);
      p0 = pops;
      c0 = cyc;
      for (int i = 0; i < PACK; i++) send_psum((i % 2 == 0) ? tbl[r].pe : tbl[r].po);
      chk("throughput_cycles", cyc - c0, PACK);
      @(negedge clk_in);
      chk("valid_next_cycle", bus.act_valid, 1);
      wait_pops(p0 + 1, "vec_word_count");
      chk("vec_word", last_word, tbl[r].exp);
    end

    // Per-channel threshold: ch3 = 100, passes 100 / 99 / 100
    for (int k = 0; k < O_CH; k++) load_thr((k == 3) ? 100 : 0, 0);
    p0 = pops;
    for (int i = 0; i < PACK; i++) send_psum((i == 3 || i == 21) ? 100 : (i == 12) ? 99 : 0);
    wait_pops(p0 + 1, "ch3_count");
    chk("ch3_word", last_word, 27'h7FFEFFF);

    // Backpressure: 81 psums with consumer stalled
    for (int k = 0; k < O_CH; k++) load_thr(0, 0);
    bus.act_ready = 0;
    p0 = pops; acc = 0; bpn = 0; stalled = 0;
    bus.psum_valid = 1; bus.psum_in = WIDTH'($urandom);
    while (!stalled && acc < 81 && bpn < 200) begin
      @(negedge clk_in); bpn++;
      if (bus.psum_ready) begin acc++; tick(); bus.psum_in = WIDTH'($urandom); end
      else stalled = 1;
    end
    chk("stall_after_54", acc, 54);
    chk("no_pop_while_stalled", pops, p0);
    tick();
    bus.act_ready = 1;
    while (acc < 81 && bpn < 400) begin
      @(negedge clk_in); bpn++;
      if (bus.psum_ready) acc++;
      tick();
      bus.psum_in = WIDTH'($urandom);
    end
    bus.psum_valid = 0;
    chk("bp_accepts", acc, 81);
    wait_pops(p0 + 3, "bp_three_words");
    repeat (5) tick();
    chk("bp_no_extra", pops, p0 + 3);

    // Flush of a partial word, channel restart, empty flush
    for (int k = 0; k < O_CH; k++) load_thr((k == 0) ? 50 : 0, 0);
    p0 = pops;
    for (int i = 0; i < 10; i++) send_psum(60);
    do_flush();
    wait_pops(p0 + 1, "flush_count");
    chk("flush_word", last_word, 27'h00003FF);
    send_psum(10);
    do_flush();
    wait_pops(p0 + 2, "flush_ch0_count");
    chk("flush_ch0_word", last_word, 27'h0);
    do_flush();
    repeat (6) tick();
    chk("empty_flush_no_word", pops, p0 + 2);

`ifdef BN_FLIP_EN
    // Flip bit on channel 0
    for (int k = 0; k < O_CH; k++) load_thr(0, k == 0);
    p0 = pops;
    for (int i = 0; i < PACK; i++) send_psum(1);
    wait_pops(p0 + 1, "flip_count");
    chk("flip_word", last_word, 27'h7FBFDFE);
`endif

    // Reset mid-word: partial state dropped, next word aligned from bit 0
    for (int k = 0; k < O_CH; k++) load_thr(0, 0);
    for (int i = 0; i < 5; i++) send_psum(7);
    rst_in = 1;
    #1;
    chk("mid_rst_valid", bus.act_valid, 0);
    repeat (2) tick();
    rst_in = 0;
    tick();
    for (int k = 0; k < O_CH; k++) load_thr(0, 0);
    p0 = pops;
    for (int i = 0; i < PACK; i++) send_psum((i % 2 == 0) ? 5 : -3);
    wait_pops(p0 + 1, "post_rst_count");
    chk("post_rst_word", last_word, 27'h5555555);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.thr_load   = ($urandom_range(19) == 0);
      bus.thr_data   = TW'($urandom_range(100)) - TW'(50);
      bus.psum_valid = ($urandom_range(9) < 7);
      bus.psum_in    = ($urandom_range(15) == 0) ? WIDTH'($urandom) :
                       WIDTH'(int'($urandom_range(120)) - 60);
      bus.flush      = ($urandom_range(24) == 0);
      bus.act_ready  = ($urandom_range(9) < 6);
      tick();
    end
    bus.thr_load = 0; bus.psum_valid = 0; bus.flush = 0; bus.act_ready = 1;
    do_flush();
    repeat (10) tick();
    @(negedge clk_in);
    chk("drain_act_valid", bus.act_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
